// File: rtl/addr_mode_sequencer.sv
// rtl/addr_mode_sequencer.sv - latches and decodes the opcode, then steps the addressing state for its mode
module addr_mode_sequencer #(
    parameter int NUM_MODES = 10,
    parameter int A_W       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           opcode,
    input  logic                 opcode_valid,
    input  logic                 rdy,
    input  logic                 carry_from_low_op,
    input  logic                 exec_done,
    output logic [7:0]           opCode_q,
    output logic [A_W-1:0]       state,
    output logic [NUM_MODES-1:0] mode_sel,
    output logic                 addr_active,
    output logic                 exec_active,
    output logic                 addr_done,
    output logic                 carry_to_high_op,
    output logic                 is_store_acc,
    output logic                 is_store_x,
    output logic                 is_store_y
);

    localparam int M_IMM   = 0;
    localparam int M_IMPL  = 1;
    localparam int M_ZPG   = 2;
    localparam int M_ZPG_X = 3;
    localparam int M_ZPG_Y = 4;
    localparam int M_ABS   = 5;
    localparam int M_ABS_X = 6;
    localparam int M_ABS_Y = 7;
    localparam int M_IND_X = 8;
    localparam int M_IND_Y = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_EXEC = 2'd2
    } fsm_t;

    fsm_t                 fsm_q, fsm_d;
    logic [7:0]           opcode_q, opcode_d;
    logic [A_W-1:0]       state_q, state_d;
    logic [NUM_MODES-1:0] mode_q, mode_d;
    logic                 carry_q, carry_d;

    logic [NUM_MODES-1:0] dec_mode;
    logic [A_W-1:0]       last_state;

    // cc=11 has no defined group; it is decoded like cc=01.
    function automatic logic [NUM_MODES-1:0] decode(input logic [7:0] op);
        logic [NUM_MODES-1:0] m;
        m = '0;
        if (op == 8'h96 || op == 8'hB6) begin
            m[M_ZPG_Y] = 1'b1;
        end else if (op == 8'hBE) begin
            m[M_ABS_Y] = 1'b1;
        end else if (op == 8'h20 || op == 8'h4C) begin
            m[M_ABS] = 1'b1;
        end else if (op[0]) begin
            case (op[4:2])
                3'b000:  m[M_IND_X] = 1'b1;
                3'b001:  m[M_ZPG]   = 1'b1;
                3'b010:  m[M_IMM]   = 1'b1;
                3'b011:  m[M_ABS]   = 1'b1;
                3'b100:  m[M_IND_Y] = 1'b1;
                3'b101:  m[M_ZPG_X] = 1'b1;
                3'b110:  m[M_ABS_Y] = 1'b1;
                default: m[M_ABS_X] = 1'b1;
            endcase
        end else begin
            case (op[4:2])
                3'b000:  m[op[7] ? M_IMM : M_IMPL] = 1'b1;
                3'b001:  m[M_ZPG]   = 1'b1;
                3'b011:  m[M_ABS]   = 1'b1;
                3'b101:  m[M_ZPG_X] = 1'b1;
                3'b111:  m[M_ABS_X] = 1'b1;
                default: m[M_IMPL]  = 1'b1;
            endcase
        end
        return m;
    endfunction

    function automatic logic has_addr(input logic [NUM_MODES-1:0] m);
        return !(m[M_IMM] || m[M_IMPL]);
    endfunction

    // Final addressing state is the mode's cycle count minus one.
    function automatic logic [A_W-1:0] last_of(input logic [NUM_MODES-1:0] m);
        logic [A_W-1:0] l;
        l = '0;
        if (m[M_ZPG_X] || m[M_ZPG_Y] || m[M_ABS]) l = 2'd1;
        if (m[M_ABS_X] || m[M_ABS_Y])             l = 2'd2;
        if (m[M_IND_X] || m[M_IND_Y])             l = 2'd3;
        return l;
    endfunction

    assign dec_mode   = decode(opcode);
    assign last_state = last_of(mode_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= S_IDLE;
            opcode_q <= 8'h00;
            state_q  <= '0;
            mode_q   <= '0;
            carry_q  <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            opcode_q <= opcode_d;
            state_q  <= state_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        opcode_d = opcode_q;
        state_d  = state_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        if (rdy) begin
            case (fsm_q)
                S_IDLE: begin
                    if (opcode_valid) begin
                        opcode_d = opcode;
                        mode_d   = dec_mode;
                        state_d  = '0;
                        if (has_addr(dec_mode)) begin
                            fsm_d = S_ADDR;
                        end else begin
                            fsm_d   = S_EXEC;
                            carry_d = 1'b0;
                        end
                    end
                end
                S_ADDR: begin
                    if (mode_q[M_IND_Y] && state_q == 2'd1) begin
                        carry_d = carry_from_low_op;
                    end
                    if (state_q == last_state) begin
                        fsm_d   = S_EXEC;
                        state_d = '0;
                        carry_d = 1'b0;
                    end else begin
                        state_d = state_q + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        fsm_d = S_IDLE;
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    assign opCode_q         = opcode_q;
    assign state            = state_q;
    assign mode_sel         = mode_q;
    assign carry_to_high_op = carry_q;
    assign addr_active      = (fsm_q == S_ADDR);
    assign exec_active      = (fsm_q == S_EXEC);
    assign addr_done        = addr_active && (state_q == last_state);

    assign is_store_acc = (opcode_q[7:5] == 3'b100) && (opcode_q[1:0] == 2'b01) && (opcode_q != 8'h89);
    assign is_store_x   = (opcode_q == 8'h86) || (opcode_q == 8'h8E) || (opcode_q == 8'h96);
    assign is_store_y   = (opcode_q == 8'h84) || (opcode_q == 8'h8C) || (opcode_q == 8'h94);

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// tb/tb_addr_mode_sequencer.sv - directed checks of addr_mode_sequencer
module tb_addr_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] opcode;
    logic       opcode_valid;
    logic       rdy;
    logic       carry_from_low_op;
    logic       exec_done;
    logic [7:0] opCode_q;
    logic [1:0] state;
    logic [9:0] mode_sel;
    logic       addr_active;
    logic       exec_active;
    logic       addr_done;
    logic       carry_to_high_op;
    logic       is_store_acc;
    logic       is_store_x;
    logic       is_store_y;

    int checks = 0;
    int errors = 0;

    addr_mode_sequencer #(.NUM_MODES(10), .A_W(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .opcode            (opcode),
        .opcode_valid      (opcode_valid),
        .rdy               (rdy),
        .carry_from_low_op (carry_from_low_op),
        .exec_done         (exec_done),
        .opCode_q          (opCode_q),
        .state             (state),
        .mode_sel          (mode_sel),
        .addr_active       (addr_active),
        .exec_active       (exec_active),
        .addr_done         (addr_done),
        .carry_to_high_op  (carry_to_high_op),
        .is_store_acc      (is_store_acc),
        .is_store_x        (is_store_x),
        .is_store_y        (is_store_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an opcode for one IDLE cycle; on return the FSM has left IDLE.
    task automatic issue(input logic [7:0] op);
        opcode       = op;
        opcode_valid = 1'b1;
        tick();
        opcode_valid = 1'b0;
    endtask

    task automatic finish_exec();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; opcode = 8'h00; opcode_valid = 1'b0; rdy = 1'b1;
        carry_from_low_op = 1'b0; exec_done = 1'b0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_opcode", opCode_q, 8'h00);
        chk("rst_mode", mode_sel, 0);
        chk("rst_status", {addr_active, exec_active, addr_done, carry_to_high_op,
                           is_store_acc, is_store_x, is_store_y}, 0);
        rst = 1'b0;
        tick();

        // LDA (zp,X) interrupted by reset at A2
        issue(8'hA1);
        chk("indx_mode", mode_sel, 10'h100);
        tick(); tick();
        chk("indx_a2", state, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_mode", mode_sel, 0);
        chk("async_rst_addr_active", addr_active, 0);
        tick();
        rst = 1'b0;
        tick();

        // LDA zpg
        issue(8'hA5);
        chk("zpg_mode", mode_sel, 10'h004);
        chk("zpg_opcode", opCode_q, 8'hA5);
        chk("zpg_a0", {addr_active, state, addr_done}, {1'b1, 2'd0, 1'b1});
        tick();
        chk("zpg_exec", {exec_active, addr_active, state}, {1'b1, 1'b0, 2'd0});
        finish_exec();
        chk("zpg_idle", {exec_active, addr_active}, 0);

        // LDA abs,X
        issue(8'hBD);
        chk("absx_mode", mode_sel, 10'h040);
        chk("absx_a0", {addr_active, state, addr_done}, {1'b1, 2'd0, 1'b0});
        tick();
        chk("absx_a1", {addr_active, state, addr_done}, {1'b1, 2'd1, 1'b0});
        tick();
        chk("absx_a2", {addr_active, state, addr_done}, {1'b1, 2'd2, 1'b1});
        tick();
        chk("absx_exec", {exec_active, addr_active}, 2'b10);
        finish_exec();

        // LDA (zp),Y with a page-cross carry at A1
        issue(8'hB1);
        chk("indy_mode", mode_sel, 10'h200);
        chk("indy_a0_carry", carry_to_high_op, 0);
        tick();
        chk("indy_a1", {state, carry_to_high_op}, {2'd1, 1'b0});
        carry_from_low_op = 1'b1;
        tick();
        carry_from_low_op = 1'b0;
        chk("indy_a2_carry", {state, carry_to_high_op}, {2'd2, 1'b1});
        tick();
        chk("indy_a3_carry", {state, carry_to_high_op, addr_done}, {2'd3, 1'b1, 1'b1});
        tick();
        chk("indy_exec_carry", {exec_active, carry_to_high_op}, 2'b10);
        finish_exec();

        // STX zpg,Y
        issue(8'h96);
        chk("stx_mode", mode_sel, 10'h010);
        chk("stx_store", {is_store_acc, is_store_x, is_store_y}, 3'b010);
        chk("stx_a0", {state, addr_done}, {2'd0, 1'b0});
        tick();
        chk("stx_a1", {addr_active, state, addr_done}, {1'b1, 2'd1, 1'b1});
        tick();
        chk("stx_exec", exec_active, 1);
        finish_exec();

        // ADC abs with rdy held low at A1
        issue(8'h6D);
        chk("adc_mode", mode_sel, 10'h020);
        chk("adc_store", {is_store_acc, is_store_x, is_store_y}, 3'b000);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("adc_rdy_hold", {addr_active, exec_active, state, addr_done}, {1'b1, 1'b0, 2'd1, 1'b1});
        end
        rdy = 1'b1;
        tick();
        chk("adc_exec", {exec_active, addr_active, state}, {1'b1, 1'b0, 2'd0});
        finish_exec();

        // INX: no addressing cycles
        issue(8'hE8);
        chk("inx_mode", mode_sel, 10'h002);
        chk("inx_exec", {exec_active, addr_active, addr_done}, 3'b100);

        // Opcode presented together with exec_done is not taken until IDLE
        opcode = 8'hA9; opcode_valid = 1'b1; exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("overlap_idle", {exec_active, addr_active, opCode_q}, {2'b00, 8'hE8});
        tick();
        opcode_valid = 1'b0;
        chk("overlap_accept", {exec_active, opCode_q, mode_sel}, {1'b1, 8'hA9, 10'h001});
        finish_exec();

        // STA abs store decode
        issue(8'h8D);
        chk("sta_store", {is_store_acc, is_store_x, is_store_y, mode_sel}, {3'b100, 10'h020});
        tick(); tick();
        finish_exec();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
